// File: rtl/packet_fifo_sync.sv
// Single-clock packet FIFO: the writer stages words and then commits or rolls back the packet.
// The reader only ever sees committed words; oversize packets are dropped at commit.
module packet_fifo_sync #(
  parameter int DATA_WIDTH = 9,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  writeEn,
  input  logic                  commitWrite,
  input  logic                  rollbackWrite,
  input  logic                  readEn,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  dataValid,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH:0]   stagedCount,
  output logic                  overflow,
  output logic                  dropPulse
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] ONE_P   = PTR_W'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rdPtr, cmtPtr, wrPtr;
  logic [PTR_W-1:0] wrPtrNext;
  logic wrAccept, lostWord, ovfNow, rdFire, doCommit, doDiscard, dropNow;

  assign count       = cmtPtr - rdPtr;
  assign stagedCount = wrPtr - cmtPtr;
  assign full        = (wrPtr - rdPtr) == DEPTH_P;
  assign empty       = (cmtPtr == rdPtr);

  // A word lost to full in the commit cycle itself still poisons the packet.
  always_comb begin
    wrAccept  = writeEn && !full && !rollbackWrite;
    lostWord  = writeEn && full && !rollbackWrite;
    ovfNow    = overflow || lostWord;
    rdFire    = readEn && !empty;
    wrPtrNext = wrPtr + (wrAccept ? ONE_P : '0);
    doCommit  = commitWrite && !rollbackWrite && !ovfNow;
    doDiscard = rollbackWrite || (commitWrite && ovfNow);
    dropNow   = rollbackWrite ? ((stagedCount != '0) || overflow || writeEn)
                              : (commitWrite && ovfNow);
  end

  always_ff @(posedge clk) begin
    if (wrAccept) mem[wrPtr[ADDR_WIDTH-1:0]] <= dataIn;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdPtr     <= '0;
      cmtPtr    <= '0;
      wrPtr     <= '0;
      dataOut   <= '0;
      dataValid <= 1'b0;
      overflow  <= 1'b0;
      dropPulse <= 1'b0;
    end else begin
      dataValid <= rdFire;
      dropPulse <= dropNow;
      if (rdFire) begin
        dataOut <= mem[rdPtr[ADDR_WIDTH-1:0]];
        rdPtr   <= rdPtr + ONE_P;
      end
      if (doDiscard) wrPtr <= cmtPtr;
      else           wrPtr <= wrPtrNext;
      if (doCommit) cmtPtr <= wrPtrNext;
      if (commitWrite || rollbackWrite) overflow <= 1'b0;
      else if (lostWord)                overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_packet_fifo_sync.sv
// Bench for packet_fifo_sync (DEPTH=4): directed steps plus random traffic vs a queue model.
module tb_packet_fifo_sync;

  localparam int DW = 9;
  localparam int D  = 4;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [DW-1:0] dataIn = '0;
  logic writeEn = 1'b0, commitWrite = 1'b0, rollbackWrite = 1'b0, readEn = 1'b0;
  logic [DW-1:0] dataOut;
  logic dataValid, empty, full, overflow, dropPulse;
  logic [AW:0] count, stagedCount;

  packet_fifo_sync #(.DATA_WIDTH(DW), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .dataIn(dataIn), .writeEn(writeEn),
    .commitWrite(commitWrite), .rollbackWrite(rollbackWrite), .readEn(readEn),
    .dataOut(dataOut), .dataValid(dataValid), .empty(empty), .full(full),
    .count(count), .stagedCount(stagedCount), .overflow(overflow), .dropPulse(dropPulse)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: committed and staged words as queues.
  logic [DW-1:0] cq[$];
  logic [DW-1:0] sq[$];
  logic mOvf = 1'b0;
  logic [DW-1:0] mData = '0;
  logic mValid = 1'b0;
  logic mDrop = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    chk("dataOut", 32'(dataOut), 32'(mData));
    chk("dataValid", 32'(dataValid), 32'(mValid));
    chk("empty", 32'(empty), 32'(cq.size() == 0));
    chk("full", 32'(full), 32'((cq.size() + sq.size()) == D));
    chk("count", 32'(count), 32'(cq.size()));
    chk("stagedCount", 32'(stagedCount), 32'(sq.size()));
    chk("overflow", 32'(overflow), 32'(mOvf));
    chk("dropPulse", 32'(dropPulse), 32'(mDrop));
  endtask

  task automatic modelReset();
    cq.delete(); sq.delete();
    mOvf = 1'b0; mData = '0; mValid = 1'b0; mDrop = 1'b0;
  endtask

  task automatic modelEdge(input logic we, input logic [DW-1:0] d,
                           input logic cm, input logic rb, input logic re);
    bit isFull = (cq.size() + sq.size()) == D;
    bit lost = we && isFull && !rb;
    mValid = 1'b0;
    mDrop = 1'b0;
    if (re && cq.size() > 0) begin
      mData = cq.pop_front();
      mValid = 1'b1;
    end
    if (we && !isFull && !rb) sq.push_back(d);
    if (rb) begin
      mDrop = (sq.size() > 0) || mOvf || we;
      sq.delete();
      mOvf = 1'b0;
    end else if (cm) begin
      if (mOvf || lost) mDrop = 1'b1;
      else foreach (sq[i]) cq.push_back(sq[i]);
      sq.delete();
      mOvf = 1'b0;
    end else if (lost) begin
      mOvf = 1'b1;
    end
  endtask

  // Called at a negedge: drive, clock once, check at the following negedge.
  task automatic step(input logic we, input logic [DW-1:0] d,
                      input logic cm, input logic rb, input logic re);
    writeEn = we; dataIn = d; commitWrite = cm; rollbackWrite = rb; readEn = re;
    @(posedge clk);
    modelEdge(we, d, cm, rb, re);
    @(negedge clk);
    writeEn = 1'b0; commitWrite = 1'b0; rollbackWrite = 1'b0; readEn = 1'b0;
    checkAll();
  endtask

  initial begin
    modelReset();
    repeat (2) @(negedge clk);
    checkAll();
    reset = 1'b1;
    @(negedge clk);
    checkAll();

    // Single word commit and read-back
    step(1, 9'h118, 0, 0, 0);
    step(0, '0, 1, 0, 0);
    step(0, '0, 0, 0, 1);
    chk("first_read", 32'(dataOut), 32'h118);

    // Rollback of a two-word packet, then a clean one-word packet
    step(1, 9'h164, 0, 0, 0);
    step(1, 9'h0A5, 0, 0, 0);
    step(0, '0, 0, 1, 0);
    step(1, 9'h001, 1, 0, 0);
    step(0, '0, 0, 0, 1);
    chk("after_rollback_read", 32'(dataOut), 32'h001);
    step(0, '0, 0, 0, 1);

    // Oversize packet dropped at commit
    for (int i = 0; i < 5; i++) step(1, DW'(9'h10 + i), 0, 0, 0);
    step(0, '0, 1, 0, 0);
    step(0, '0, 0, 0, 0);

    // Wrap-around
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 3; i++) step(1, DW'(9'h40 + 3 * r + i), 0, 0, 0);
      step(0, '0, 1, 0, 0);
      for (int i = 0; i < 3; i++) step(0, '0, 0, 0, 1);
    end

    // Same-cycle write+commit, then write+commit+rollback
    step(1, 9'h030, 0, 0, 0);
    step(1, 9'h031, 0, 0, 0);
    step(1, 9'h033, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, '0, 0, 0, 1);
    step(1, 9'h044, 0, 0, 0);
    step(1, 9'h055, 1, 1, 0);
    step(0, '0, 0, 0, 0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic we, cm, rb, re;
      we = ($urandom_range(0, 99) < 60);
      cm = ($urandom_range(0, 99) < 18);
      rb = ($urandom_range(0, 99) < 5);
      re = ($urandom_range(0, 99) < 40);
      step(we, DW'($urandom), cm, rb, re);
    end

    // Asynchronous reset mid-packet: one committed, two staged
    step(0, '0, 0, 1, 0);
    while (cq.size() > 0) step(0, '0, 0, 0, 1);
    step(1, 9'h0C1, 1, 0, 0);
    step(1, 9'h0C2, 0, 0, 0);
    step(1, 9'h0C3, 0, 0, 0);
    chk("pre_reset_count", 32'(count), 32'd1);
    #1 reset = 1'b0;
    #1 modelReset();
    checkAll();
    @(negedge clk);
    reset = 1'b1;
    step(1, 9'h0D7, 1, 0, 0);
    step(0, '0, 0, 0, 1);
    chk("post_reset_read", 32'(dataOut), 32'h0D7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
